// File: rtl/serial_adder.sv
// Bit-serial ripple adder: two half adders plus an OR form a full adder, and a carry register chains the bits LSB first.
// Latency: out_valid rises WIDTH edges after the accepting edge; accepts are at least WIDTH+2 cycles apart.
// Backpressure: in_ready is low outside IDLE; the result is held in DONE until out_ready is seen.

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // One extra bit beyond log2 so the terminal compare never sees a wrapped count.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CW-1:0]    count;

  logic ha0_sum;
  logic ha0_carry;
  logic ha1_sum;
  logic ha1_carry;
  logic bit_sum;
  logic bit_carry;
  logic last_bit;
  logic accept;
  logic [WIDTH:0] sum_shift;

  // Full adder on the current LSB of each operand and the running carry.
  half_adder ha0 (
    .a     (op_a[0]),
    .b     (op_b[0]),
    .sum   (ha0_sum),
    .carry (ha0_carry)
  );

  half_adder ha1 (
    .a     (ha0_sum),
    .b     (carry),
    .sum   (ha1_sum),
    .carry (ha1_carry)
  );

  assign bit_sum   = ha1_sum;
  assign bit_carry = ha0_carry | ha1_carry;

  assign last_bit  = (count == CW'(WIDTH - 1));
  assign in_ready  = (state == IDLE);
  assign accept    = in_valid & in_ready;

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands in sum[0].
  assign sum_shift = {bit_sum, sum};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: accept in IDLE, run WIDTH bit-times, hold the result until taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid)  state_next = RUN;
      RUN:  if (last_bit)  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // out_valid is a flop of its own so downstream sees a clean registered qualifier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_next == DONE);
    end
  end

  // Datapath: load on accept, shift one bit per RUN edge, capture cout on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= b;
      carry <= cin;
      count <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      sum   <= sum_shift[WIDTH:1];
      carry <= bit_carry;
      count <= count + CW'(1);
      if (last_bit) begin
        cout <= bit_carry;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 and WIDTH=1 instances share clock and reset.
// Expected {cout,sum} is queued when an input handshake is seen; monitors pop on output handshakes.
// Inputs change #1 after the rising edge; monitors sample on the falling edge.

module tb_serial_adder;

  localparam int PERIOD = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       in_valid8 = 1'b0;
  logic       in_ready8;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       out_valid8;
  logic       out_ready8 = 1'b1;
  logic [7:0] sum8;
  logic       cout8;

  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       cin1 = 1'b0;
  logic       out_valid1;
  logic       out_ready1 = 1'b1;
  logic [0:0] sum1;
  logic       cout1;

  logic [8:0] exp8_next = '0;
  logic [1:0] exp1_next = '0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];

  int  n_checks = 0;
  int  n_fail   = 0;
  time acc8_t   = 0;
  time acc1_t   = 0;
  bit  have_prev8 = 1'b0;
  bit  b2b        = 1'b0;
  logic prev_ov8  = 1'b0;
  logic prev_ov1  = 1'b0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1)
  );

  initial forever #(PERIOD/2) clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at t=%0t", name, $time);
  endtask

  // Input-side scoreboard feed for the 8-bit DUT; also checks back-to-back accept spacing.
  always @(negedge clk) begin
    if (!rst && in_valid8 && in_ready8) begin
      q8.push_back(exp8_next);
      if (b2b && have_prev8)
        check("b2b_spacing", 32'($time + PERIOD/2 - acc8_t), 32'((8 + 2) * PERIOD));
      acc8_t     = $time + PERIOD/2;
      have_prev8 = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst && in_valid1 && in_ready1) begin
      q1.push_back(exp1_next);
      acc1_t = $time + PERIOD/2;
    end
  end

  // Output monitor for the 8-bit DUT: latency on the rising out_valid, data on each handshake.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst) begin
      if (out_valid8 && !prev_ov8)
        check("latency8", 32'($time - acc8_t), 32'(8 * PERIOD + PERIOD/2));
      if (out_valid8 && out_ready8) begin
        if (q8.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected8: result sum=0x%0h cout=%0b with nothing expected", sum8, cout8);
        end else begin
          e = q8.pop_front();
          check("sum8", 32'(sum8), 32'(e[7:0]));
          check("cout8", 32'(cout8), 32'(e[8]));
        end
      end
    end
    prev_ov8 = rst ? 1'b0 : out_valid8;
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst) begin
      if (out_valid1 && !prev_ov1)
        check("latency1", 32'($time - acc1_t), 32'(1 * PERIOD + PERIOD/2));
      if (out_valid1 && out_ready1) begin
        if (q1.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected1: result sum=%0b cout=%0b with nothing expected", sum1, cout1);
        end else begin
          e = q1.pop_front();
          check("sum1", 32'(sum1), 32'(e[0]));
          check("cout1", 32'(cout1), 32'(e[1]));
        end
      end
    end
    prev_ov1 = rst ? 1'b0 : out_valid1;
  end

  // Present one operand set, hold it for the accepting edge, then scramble the inputs.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [8:0] e);
    int n = 0;
    while (!in_ready8 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready8) timeout("send8_ready");
    a8 = a; b8 = b; cin8 = c; exp8_next = e; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    a8 = ~a; b8 = ~b; cin8 = ~c;
  endtask

  task automatic send1(input logic a, input logic b, input logic c, input logic [1:0] e);
    int n = 0;
    while (!in_ready1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready1) timeout("send1_ready");
    a1 = a; b1 = b; cin1 = c; exp1_next = e; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    a1 = ~a; b1 = ~b; cin1 = ~c;
  endtask

  task automatic drain8();
    int n = 0;
    while ((q8.size() != 0 || !in_ready8) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (q8.size() != 0 || !in_ready8) timeout("drain8");
  endtask

  task automatic drain1();
    int n = 0;
    while ((q1.size() != 0 || !in_ready1) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (q1.size() != 0 || !in_ready1) timeout("drain1");
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [8:0] e;
  } vec_t;

  vec_t dir_vecs[4] = '{
    '{8'h00, 8'h00, 1'b0, 9'h000},
    '{8'hFF, 8'h01, 1'b0, 9'h100},
    '{8'hA5, 8'h5A, 1'b1, 9'h100},
    '{8'h3C, 8'h42, 1'b0, 9'h07E}
  };

  vec_t b2b_vecs[5] = '{
    '{8'h01, 8'h02, 1'b0, 9'h003},
    '{8'h7F, 8'h01, 1'b0, 9'h080},
    '{8'hFF, 8'hFF, 1'b1, 9'h1FF},
    '{8'h55, 8'hAA, 1'b0, 9'h0FF},
    '{8'hC8, 8'h64, 1'b1, 9'h12D}
  };

  initial begin
    // Reset values while rst is held.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready8",  32'(in_ready8),  32'd1);
    check("rst_out_valid8", 32'(out_valid8), 32'd0);
    check("rst_sum8",       32'(sum8),       32'h00);
    check("rst_cout8",      32'(cout8),      32'd0);
    check("rst_in_ready1",  32'(in_ready1),  32'd1);
    check("rst_out_valid1", 32'(out_valid1), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed sums.
    foreach (dir_vecs[i]) begin
      send8(dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].c, dir_vecs[i].e);
      drain8();
    end

    // Backpressure: result held in DONE, a stray in_valid ignored.
    out_ready8 = 1'b0;
    send8(8'h80, 8'h80, 1'b0, 9'h100);
    begin
      int n = 0;
      while (!out_valid8 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (!out_valid8) timeout("bp_out_valid");
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin a8 = 8'h11; b8 = 8'h11; cin8 = 1'b0; in_valid8 = 1'b1; end
      if (i == 2) in_valid8 = 1'b0;
      @(posedge clk); #1;
      check("bp_sum",       32'(sum8),       32'h00);
      check("bp_cout",      32'(cout8),      32'd1);
      check("bp_in_ready",  32'(in_ready8),  32'd0);
      check("bp_out_valid", 32'(out_valid8), 32'd1);
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready",  32'(in_ready8),  32'd1);
    check("bp_release_out_valid", 32'(out_valid8), 32'd0);
    check("bp_release_cout_kept", 32'(cout8),      32'd1);
    drain8();

    // Reset in the middle of RUN aborts with no result.
    send8(8'h0F, 8'h01, 1'b0, 9'h010);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    q8.delete();
    #1;
    check("abort_out_valid", 32'(out_valid8), 32'd0);
    check("abort_sum",       32'(sum8),       32'h00);
    check("abort_cout",      32'(cout8),      32'd0);
    check("abort_in_ready",  32'(in_ready8),  32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    send8(8'h0F, 8'h01, 1'b0, 9'h010);
    drain8();

    // Back-to-back: in_valid stays high, new operands after each accept.
    b2b = 1'b1;
    have_prev8 = 1'b0;
    foreach (b2b_vecs[i]) begin
      a8 = b2b_vecs[i].a; b8 = b2b_vecs[i].b; cin8 = b2b_vecs[i].c;
      exp8_next = b2b_vecs[i].e;
      in_valid8 = 1'b1;
      begin
        int n = 0;
        while (!in_ready8 && n < 50) begin
          @(posedge clk); #1;
          n++;
        end
        if (!in_ready8) timeout("b2b_ready");
      end
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    drain8();
    b2b = 1'b0;

    // Random operands against a plain integer sum.
    repeat (200) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      send8(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'd0, rc});
      drain8();
    end

    // Single-bit instance.
    send1(1'b1, 1'b1, 1'b1, 2'b11);
    drain1();
    send1(1'b1, 1'b0, 1'b0, 2'b01);
    drain1();

    check("q8_empty", 32'(q8.size()), 32'd0);
    check("q1_empty", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
